// File: rtl/int_rx.sv
// int_rx: receive-side bridge between the UART RX FIFO and the ALU.
// Pops three bytes per command frame (operand A, operand B, opcode) and
// publishes them to the ALU atomically, then raises a one-cycle `enviar`
// toward the transmit-side interface once it is free.
//
// Optional feature macro: INT_RX_OPCHECK_EN
//   defined   -> opcode byte is checked against the ALU opcode set; frames
//                with an unknown opcode are dropped through the ERROR state
//                and reported with a one-cycle `op_error` pulse.
//   undefined -> every opcode is accepted, `op_error` is tied low and the
//                ERROR state does not exist.
module int_rx #(
  parameter int N_BITS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fifo_empty,
  input  logic [N_BITS-1:0] data_fifo,
  output logic              RD_FIFO,
  input  logic              tx_busy,
  output logic [N_BITS-1:0] DATO_A,
  output logic [N_BITS-1:0] DATO_B,
  output logic [N_BITS-1:0] OPCODE,
  output logic              enviar,
  output logic              op_error,
  output logic [2:0]        STATE
);

  // Encodings are visible on STATE and shared with the TX-side interface.
  typedef enum logic [2:0] {
    ESP_A  = 3'd0,
    ESP_B  = 3'd1,
    ESP_OP = 3'd2,
`ifdef INT_RX_OPCHECK_EN
    EMITIR = 3'd3,
    ERROR  = 3'd4
`else
    EMITIR = 3'd3
`endif
  } state_t;

  state_t            state_q;
  logic [N_BITS-1:0] sh_a_q;    // operand A shadow, not yet visible to the ALU
  logic [N_BITS-1:0] sh_b_q;    // operand B shadow, not yet visible to the ALU
  logic [N_BITS-1:0] dato_a_q;
  logic [N_BITS-1:0] dato_b_q;
  logic [N_BITS-1:0] opcode_q;

  logic waiting;  // in one of the byte-collecting states
  logic pop;      // head word is consumed on this edge
  logic op_ok;    // opcode byte may be forwarded to the ALU

`ifdef INT_RX_OPCHECK_EN
  // Opcodes implemented by the ALU.
  function automatic logic op_valid(input logic [N_BITS-1:0] op);
    logic ok;
    case (op)
      N_BITS'(8'h20), N_BITS'(8'h22), N_BITS'(8'h24), N_BITS'(8'h25),
      N_BITS'(8'h26), N_BITS'(8'h27), N_BITS'(8'h03), N_BITS'(8'h02): ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign op_ok = op_valid(data_fifo);
`else
  assign op_ok = 1'b1;
`endif

  assign waiting = (state_q == ESP_A) || (state_q == ESP_B) || (state_q == ESP_OP);
  assign pop     = waiting && !fifo_empty;

  // Handshake strobes are combinational from state and inputs, masked in reset.
  always_comb begin
    RD_FIFO  = 1'b0;
    enviar   = 1'b0;
    op_error = 1'b0;
    if (!RESET) begin
      RD_FIFO = pop;
      enviar  = (state_q == EMITIR) && !tx_busy;
`ifdef INT_RX_OPCHECK_EN
      op_error = (state_q == ERROR);
`endif
    end
  end

  // Frame assembly FSM; ALU-facing registers only move on ESP_OP -> EMITIR.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ESP_A;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      opcode_q <= '0;
    end else begin
      case (state_q)
        ESP_A: begin
          if (pop) begin
            sh_a_q  <= data_fifo;
            state_q <= ESP_B;
          end
        end
        ESP_B: begin
          if (pop) begin
            sh_b_q  <= data_fifo;
            state_q <= ESP_OP;
          end
        end
        ESP_OP: begin
          if (pop) begin
            if (op_ok) begin
              opcode_q <= data_fifo;
              dato_a_q <= sh_a_q;
              dato_b_q <= sh_b_q;
              state_q  <= EMITIR;
            end
`ifdef INT_RX_OPCHECK_EN
            else begin
              state_q <= ERROR;
            end
`endif
          end
        end
        EMITIR: begin
          if (!tx_busy) state_q <= ESP_A;
        end
`ifdef INT_RX_OPCHECK_EN
        ERROR: begin
          state_q <= ESP_A;
        end
`endif
        default: state_q <= ESP_A;
      endcase
    end
  end

  assign DATO_A = dato_a_q;
  assign DATO_B = dato_b_q;
  assign OPCODE = opcode_q;
  assign STATE  = state_q;

endmodule

// File: tb/tb_int_rx.sv
// Directed bench for int_rx: a queue models the FWFT RX FIFO; each task
// drives one scenario and checks outputs on the falling edge.
module tb_int_rx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] data_fifo = 8'h00;
  logic       tx_busy = 1'b0;
  logic       RD_FIFO, enviar, op_error;
  logic [7:0] DATO_A, DATO_B, OPCODE;
  logic [2:0] STATE;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];

  always #5 CLK = ~CLK;

  int_rx #(.N_BITS(8)) dut (
    .CLK(CLK), .RESET(RESET), .fifo_empty(fifo_empty), .data_fifo(data_fifo),
    .RD_FIFO(RD_FIFO), .tx_busy(tx_busy), .DATO_A(DATO_A), .DATO_B(DATO_B),
    .OPCODE(OPCODE), .enviar(enviar), .op_error(op_error), .STATE(STATE)
  );

  task refresh();
    fifo_empty = (q.size() == 0);
    data_fifo  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  task push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // FIFO model: pop on the edge RD_FIFO is seen; never pop an empty FIFO.
  always @(posedge CLK) begin
    checks++;
    if (RD_FIFO && fifo_empty) begin
      errors++;
      $display("FAIL rd_when_empty t=%0t RD_FIFO=%b fifo_empty=%b", $time, RD_FIFO, fifo_empty);
    end
    if (RD_FIFO && q.size() > 0) void'(q.pop_front());
    #1 refresh();
  end

  task test_reset();
    RESET = 1'b1; tx_busy = 1'b0; q.delete(); refresh();
    @(posedge CLK);
    repeat (5) begin
      @(negedge CLK); #1;
      checks++;
      if (STATE !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", STATE); end
      checks++;
      if ({RD_FIFO, enviar, op_error} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {RD_FIFO, enviar, op_error}); end
      checks++;
      if ({DATO_A, DATO_B, OPCODE} !== 24'h0) begin errors++; $display("FAIL reset_regs got=%h exp=000000", {DATO_A, DATO_B, OPCODE}); end
    end
    // a queued byte must not be popped while reset is held
    push(8'hAA);
    @(negedge CLK); #1;
    checks++;
    if (RD_FIFO !== 1'b0) begin errors++; $display("FAIL reset_rd_masked got=%b exp=0", RD_FIFO); end
    @(negedge CLK);
    q.delete(); refresh();
    RESET = 1'b0;
  endtask

  task test_basic();
    logic [2:0] st[5];
    logic       rd[5];
    logic       en[5];
    st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    push(8'h0A); push(8'h05); push(8'h20);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (STATE !== st[c]) begin errors++; $display("FAIL basic_state c=%0d got=%0d exp=%0d", c + 1, STATE, st[c]); end
      checks++;
      if (RD_FIFO !== rd[c]) begin errors++; $display("FAIL basic_rd c=%0d got=%b exp=%b", c + 1, RD_FIFO, rd[c]); end
      checks++;
      if (enviar !== en[c]) begin errors++; $display("FAIL basic_enviar c=%0d got=%b exp=%b", c + 1, enviar, en[c]); end
      if (c == 3) begin
        checks++;
        if ({DATO_A, DATO_B, OPCODE} !== 24'h0A0520) begin errors++; $display("FAIL basic_regs got=%h exp=0a0520", {DATO_A, DATO_B, OPCODE}); end
      end
      @(negedge CLK);
    end
  endtask

  task test_gaps();
    push(8'h0F);
    repeat (10) @(negedge CLK);
    #1;
    checks++;
    if (STATE !== 3'd1) begin errors++; $display("FAIL gaps_state_b got=%0d exp=1", STATE); end
    checks++;
    if ({DATO_A, DATO_B, OPCODE, enviar} !== {24'h0A0520, 1'b0}) begin errors++; $display("FAIL gaps_hold_a got=%h/%b exp=0a0520/0", {DATO_A, DATO_B, OPCODE}, enviar); end
    push(8'h03);
    repeat (10) @(negedge CLK);
    #1;
    checks++;
    if (STATE !== 3'd2) begin errors++; $display("FAIL gaps_state_op got=%0d exp=2", STATE); end
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h0A0520) begin errors++; $display("FAIL gaps_hold_b got=%h exp=0a0520", {DATO_A, DATO_B, OPCODE}); end
    push(8'h22);
    #1;
    checks++;
    if (RD_FIFO !== 1'b1) begin errors++; $display("FAIL gaps_rd_op got=%b exp=1", RD_FIFO); end
    @(negedge CLK); #1;
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h0F0322) begin errors++; $display("FAIL gaps_regs got=%h exp=0f0322", {DATO_A, DATO_B, OPCODE}); end
    checks++;
    if ({STATE, enviar} !== {3'd3, 1'b1}) begin errors++; $display("FAIL gaps_emit got=%0d/%b exp=3/1", STATE, enviar); end
    @(negedge CLK);
  endtask

  task test_back_to_back();
    logic [2:0] st[8];
    logic       rd[8];
    logic       en[8];
    st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    push(8'h10); push(8'h20); push(8'h26);
    push(8'h30); push(8'h40); push(8'h27);
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({STATE, RD_FIFO, enviar} !== {st[c], rd[c], en[c]}) begin
        errors++;
        $display("FAIL b2b_cycle c=%0d got st=%0d rd=%b en=%b exp st=%0d rd=%b en=%b",
                 c + 1, STATE, RD_FIFO, enviar, st[c], rd[c], en[c]);
      end
      if (c == 3) begin
        checks++;
        if ({DATO_A, DATO_B, OPCODE} !== 24'h102026) begin errors++; $display("FAIL b2b_frame1 got=%h exp=102026", {DATO_A, DATO_B, OPCODE}); end
      end
      if (c == 7) begin
        checks++;
        if ({DATO_A, DATO_B, OPCODE} !== 24'h304027) begin errors++; $display("FAIL b2b_frame2 got=%h exp=304027", {DATO_A, DATO_B, OPCODE}); end
      end
      @(negedge CLK);
    end
  endtask

  task test_busy();
    tx_busy = 1'b1;
    push(8'h11); push(8'h12); push(8'h25);
    push(8'h0C); push(8'h0D); push(8'h03);
    repeat (3) @(negedge CLK);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({STATE, enviar, RD_FIFO} !== {3'd3, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL busy_hold c=%0d got st=%0d en=%b rd=%b exp st=3 en=0 rd=0", c, STATE, enviar, RD_FIFO);
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h111225) begin errors++; $display("FAIL busy_regs got=%h exp=111225", {DATO_A, DATO_B, OPCODE}); end
    tx_busy = 1'b0;
    #1;
    checks++;
    if ({STATE, enviar} !== {3'd3, 1'b1}) begin errors++; $display("FAIL busy_release got=%0d/%b exp=3/1", STATE, enviar); end
    @(negedge CLK); #1;
    checks++;
    if ({STATE, RD_FIFO, enviar} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL busy_after got=%0d/%b/%b exp=0/1/0", STATE, RD_FIFO, enviar); end
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({DATO_A, DATO_B, OPCODE, enviar} !== {24'h0C0D03, 1'b1}) begin errors++; $display("FAIL busy_frame2 got=%h/%b exp=0c0d03/1", {DATO_A, DATO_B, OPCODE}, enviar); end
    @(negedge CLK);
  endtask

  task test_bad_op();
    push(8'h01); push(8'h02); push(8'h55);
    repeat (3) @(negedge CLK);
    #1;
`ifdef INT_RX_OPCHECK_EN
    checks++;
    if ({STATE, op_error, enviar} !== {3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL badop_error got=%0d/%b/%b exp=4/1/0", STATE, op_error, enviar); end
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h0C0D03) begin errors++; $display("FAIL badop_regs got=%h exp=0c0d03", {DATO_A, DATO_B, OPCODE}); end
    @(negedge CLK); #1;
    checks++;
    if ({STATE, op_error, enviar} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL badop_after got=%0d/%b/%b exp=0/0/0", STATE, op_error, enviar); end
`else
    checks++;
    if ({STATE, op_error, enviar} !== {3'd3, 1'b0, 1'b1}) begin errors++; $display("FAIL anyop_emit got=%0d/%b/%b exp=3/0/1", STATE, op_error, enviar); end
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h010255) begin errors++; $display("FAIL anyop_regs got=%h exp=010255", {DATO_A, DATO_B, OPCODE}); end
    @(negedge CLK); #1;
    checks++;
    if ({STATE, enviar} !== {3'd0, 1'b0}) begin errors++; $display("FAIL anyop_after got=%0d/%b exp=0/0", STATE, enviar); end
`endif
    @(negedge CLK);
  endtask

  task test_reset_mid();
    push(8'h33); push(8'h44);
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (STATE !== 3'd2) begin errors++; $display("FAIL midrst_pre got=%0d exp=2", STATE); end
    RESET = 1'b1;
    @(negedge CLK); #1;
    checks++;
    if ({STATE, RD_FIFO, enviar, op_error} !== {3'd0, 3'b000}) begin errors++; $display("FAIL midrst_state got=%0d/%b%b%b exp=0/000", STATE, RD_FIFO, enviar, op_error); end
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h0) begin errors++; $display("FAIL midrst_regs got=%h exp=000000", {DATO_A, DATO_B, OPCODE}); end
    RESET = 1'b0;
    push(8'h07); push(8'h08); push(8'h24);
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({DATO_A, DATO_B, OPCODE} !== 24'h070824) begin errors++; $display("FAIL midrst_frame got=%h exp=070824", {DATO_A, DATO_B, OPCODE}); end
    checks++;
    if ({STATE, enviar} !== {3'd3, 1'b1}) begin errors++; $display("FAIL midrst_emit got=%0d/%b exp=3/1", STATE, enviar); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_busy();
    test_bad_op();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_rx.md
# int_rx

Receive-side interface between the UART RX FIFO and the ALU. It pops bytes from the RX FIFO and assembles one command frame: operand A, operand B, then opcode. It holds the assembled operands and opcode stable for the ALU, and issues a single `enviar` pulse to the transmit-side interface once the result may be sent. It is the counterpart of the ALU-to-TX-FIFO interface and shares its handshake style and 3-bit `STATE` debug port.

## Interface
- `N_BITS`, 8: data width of FIFO words, operands and opcode.
- `CLK` input 1: system clock; all logic on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `fifo_empty` input 1: RX FIFO empty flag.
- `data_fifo` input `N_BITS`: RX FIFO head word, first-word-fall-through, valid whenever `fifo_empty`=0.
- `RD_FIFO` output 1: pop strobe; head word consumed on the same rising edge.
- `tx_busy` input 1: transmit-side interface is busy and cannot accept `enviar`.
- `DATO_A` output `N_BITS`: operand A register.
- `DATO_B` output `N_BITS`: operand B register.
- `OPCODE` output `N_BITS`: opcode register.
- `enviar` output 1: one-cycle pulse; ALU result is valid and may be transmitted.
- `op_error` output 1: one-cycle pulse; frame discarded for an invalid opcode (only with `INT_RX_OPCHECK_EN`).
- `STATE` output 3: current FSM state encoding.

## Operation
- FSM states and encodings:
  - `ESP_A`=0
  - `ESP_B`=1
  - `ESP_OP`=2
  - `EMITIR`=3
  - `ERROR`=4, only reachable with `INT_RX_OPCHECK_EN`.
- `ESP_A`: `RD_FIFO`=~`fifo_empty`. On a pop, latch `data_fifo` into a shadow register for A, then go to `ESP_B`.
- `ESP_B`: same rule; latch the shadow register for B, then go to `ESP_OP`.
- `ESP_OP`: same rule on a pop:
  - latch `OPCODE`;
  - copy both shadow registers into `DATO_A` and `DATO_B` in the same edge;
  - go to `EMITIR`.
  - With `INT_RX_OPCHECK_EN` and an invalid opcode, go to `ERROR` instead and leave `OPCODE`, `DATO_A` and `DATO_B` unchanged.
- `EMITIR`: `enviar`=~`tx_busy`. When `enviar`=1, go to `ESP_A`. While `tx_busy`=1, stay in `EMITIR`. `RD_FIFO`=0 in this state.
- `ERROR`: `op_error`=1 for exactly one cycle, `RD_FIFO`=0, then go to `ESP_A`.
- `DATO_A`, `DATO_B` and `OPCODE` change only on the `ESP_OP` to `EMITIR` edge. The ALU therefore never sees a partial frame, and values hold until the next complete valid frame.
- `fifo_empty`=1 in any `ESP_*` state: hold the state, `RD_FIFO`=0. There is no timeout.
- `RD_FIFO` and `enviar` are combinational from state and inputs. All three outputs `RD_FIFO`, `enviar` and `op_error` are forced to 0 while `RESET`=1.

## Timing
- Reset values:
  - `STATE`=0 (`ESP_A`)
  - `DATO_A`=0, `DATO_B`=0, `OPCODE`=0
  - `RD_FIFO`=0, `enviar`=0, `op_error`=0
  - shadow registers = 0
- Reset mid-frame discards any partially received bytes. The first byte popped after reset is treated as operand A.
- Best-case latency: with 3 bytes already queued and `tx_busy`=0, `RD_FIFO` is high in cycles 1, 2 and 3, and `enviar` is high in cycle 4. Frame throughput is one frame per 4 cycles.
- Any number of bubbles of `fifo_empty`=1 between bytes only stretch the frame; no byte is lost or duplicated.
- `tx_busy` dropping in the same cycle the FSM enters `EMITIR` produces `enviar` in that cycle.
- At most one `RD_FIFO` per cycle. `RD_FIFO` is never asserted when `fifo_empty`=1.

## Configuration
- `INT_RX_OPCHECK_EN` defined:
  - valid opcode set: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL;
  - any other byte in the opcode slot leads to `ERROR`, a one-cycle `op_error` pulse, and the frame is dropped;
  - no `enviar` is issued for a dropped frame.
- `INT_RX_OPCHECK_EN` undefined:
  - every opcode byte is accepted;
  - `ERROR` state and check logic are absent;
  - `op_error` is tied to 0;
  - `STATE` never reads 4.

## Test plan
- Reset 5 cycles, FIFO empty: `STATE`=0, all outputs 0, `RD_FIFO` never asserted.
- FIFO preloaded with 0x0A, 0x05, 0x20, `tx_busy`=0: `RD_FIFO` high for 3 consecutive cycles. Then `DATO_A`=0x0A, `DATO_B`=0x05, `OPCODE`=0x20, and a single `enviar` pulse in cycle 4; `STATE` sequence 0,1,2,3,0.
- Bytes 0x0F, 0x03, 0x22 arriving 10 cycles apart: outputs keep the previous frame until the 0x22 pop, then `DATO_A`=0x0F, `DATO_B`=0x03, `OPCODE`=0x22.
- Complete frame with `tx_busy`=1 for 6 cycles: `STATE` holds at 3, `enviar`=0, `RD_FIFO`=0 even with bytes queued. `enviar` pulses in the cycle `tx_busy` falls.
- Frame 0x01, 0x02, 0x55:
  - with `INT_RX_OPCHECK_EN`: `op_error` pulses once, `STATE` goes 2 to 4 to 0, outputs unchanged, no `enviar`;
  - without it: `OPCODE`=0x55 and `enviar` pulses.
- `RESET` asserted after operand A and B have been popped, then frame 0x07, 0x08, 0x24: result is `DATO_A`=0x07, `DATO_B`=0x08; the pre-reset bytes are never used.
